// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state encoding, parity encodings and default parameters
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_OSR        = 16;
  localparam int DEF_DIV_W      = 16;

  // Encoding 2'b11 is reserved and behaves like no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - show-ahead receive stream between the FIFO and its consumer
interface uart_rx_param_if #(
  parameter int W = 10
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with flush and overrun pulse
module uart_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  uart_rx_param_if.master        rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd.tready & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push & (~full | do_pop) & ~flush;

  assign rd.tvalid = ~empty;
  assign rd.tdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & full & ~do_pop & ~flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver feeding a show-ahead receive FIFO
// Bit timing restarts at every start edge; a word is pushed at the mid-sample of its last stop bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int OSR        = DEF_OSR,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_en,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop_bits,
  input  logic                        flush_i,
  input  logic                        rxd_i,
  output logic [DATA_W-1:0]           m_data_o,
  output logic                        m_perr_o,
  output logic                        m_ferr_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  output logic                        overrun_o,
  output logic                        break_o
);
  localparam int HALF = OSR / 2;
  localparam int TW   = $clog2(OSR);
  localparam int BW   = $clog2(DATA_W);

  logic              sync1;
  logic              sync2;
  logic              rx_last;
  logic [1:0]        warm;
  rx_state_t         state;
  logic [DIV_W-1:0]  div_lat;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        par_lat;
  logic              stop2_lat;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [1:0]        samp;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              ferr;
  logic              any_one;
  logic              brk_pend;
  logic              push;
  logic              brk_pulse;
  logic [DATA_W+1:0] push_word;
  logic              tick;
  logic              mid;
  logic              bit_end;
  logic              maj;
  logic              start_edge;
  logic              perr_now;

  // The edge flop only follows the line once the synchroniser holds real samples,
  // so a line that is low when reset releases cannot fake a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      warm    <= 2'b00;
      rx_last <= 1'b0;
    end else begin
      sync1   <= rxd_i;
      sync2   <= sync1;
      warm    <= {warm[0], 1'b1};
      rx_last <= sync2 & warm[1];
    end
  end

  assign start_edge = rx_last & ~sync2;
  assign tick       = (div_cnt == div_lat);
  assign mid        = tick && (tick_cnt == TW'(HALF + 1));
  assign bit_end    = tick && (tick_cnt == TW'(OSR - 1));
  assign maj        = (samp[1] & samp[0]) | (samp[1] & sync2) | (samp[0] & sync2);

  always_comb begin
    perr_now = 1'b0;
    if (par_lat == PAR_ODD)       perr_now = ~(^shreg ^ par_bit);
    else if (par_lat == PAR_EVEN) perr_now = ^shreg ^ par_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_lat   <= '0;
      div_cnt   <= '0;
      par_lat   <= PAR_NONE;
      stop2_lat <= 1'b0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      samp      <= 2'b00;
      shreg     <= '0;
      par_bit   <= 1'b0;
      ferr      <= 1'b0;
      any_one   <= 1'b0;
      brk_pend  <= 1'b0;
      push      <= 1'b0;
      brk_pulse <= 1'b0;
      push_word <= '0;
    end else begin
      push      <= 1'b0;
      brk_pulse <= 1'b0;
      if (state != ST_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) begin
          tick_cnt <= (tick_cnt == TW'(OSR - 1)) ? '0 : tick_cnt + TW'(1);
          if (tick_cnt == TW'(HALF - 1) || tick_cnt == TW'(HALF))
            samp <= {samp[0], sync2};
        end
      end
      if (!rx_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (start_edge) begin
            state     <= ST_START;
            div_lat   <= baud_div;
            par_lat   <= parity_mode;
            stop2_lat <= stop_bits;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            ferr      <= 1'b0;
            any_one   <= 1'b0;
            brk_pend  <= 1'b0;
          end
          ST_START: begin
            if (mid && maj)   state <= ST_IDLE;
            else if (bit_end) state <= ST_DATA;
          end
          ST_DATA: begin
            if (mid) begin
              shreg   <= {maj, shreg[DATA_W-1:1]};
              any_one <= any_one | maj;
            end
            if (bit_end) begin
              if (bit_cnt == BW'(DATA_W - 1))
                state <= parity_on(par_lat) ? ST_PARITY : ST_STOP1;
              else
                bit_cnt <= bit_cnt + BW'(1);
            end
          end
          ST_PARITY: begin
            if (mid) begin
              par_bit <= maj;
              any_one <= any_one | maj;
            end
            if (bit_end) state <= ST_STOP1;
          end
          ST_STOP1: begin
            if (mid) begin
              if (stop2_lat) begin
                ferr     <= ~maj;
                brk_pend <= ~any_one & ~maj;
              end else begin
                push      <= 1'b1;
                brk_pulse <= ~any_one & ~maj;
                push_word <= {perr_now, ~maj, shreg};
                state     <= ST_IDLE;
              end
            end else if (bit_end) begin
              state <= ST_STOP2;
            end
          end
          ST_STOP2: if (mid) begin
            push      <= 1'b1;
            brk_pulse <= brk_pend;
            push_word <= {perr_now, ferr | ~maj, shreg};
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  uart_rx_param_if #(.W(DATA_W + 2)) rd_if ();

  uart_sync_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .push      (push),
    .push_data (push_word),
    .rd        (rd_if),
    .count     (fifo_cnt_o),
    .overrun   (overrun_o)
  );

  assign rd_if.tready                     = m_ready_i;
  assign {m_perr_o, m_ferr_o, m_data_o}   = rd_if.tdata;
  assign m_valid_o                        = rd_if.tvalid;
  assign break_o                          = brk_pulse;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
// 8 data bits, 4-entry FIFO, OSR 16, baud_div 3: one bit lasts 64 clk.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BIT   = 64;

  typedef struct packed {
    logic [1:0] mode;
    logic       two;
    logic [7:0] d;
    logic       par;
    logic       st1;
    logic       st2;
    logic       perr;
    logic       ferr;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rx_en = 1'b1;
  logic [15:0]             baud_div = 16'd3;
  logic [1:0]              parity_mode = PAR_NONE;
  logic                    stop_bits = 1'b0;
  logic                    flush = 1'b0;
  logic                    rxd = 1'b1;
  logic                    m_ready = 1'b0;
  logic [DW-1:0]           m_data;
  logic                    m_perr;
  logic                    m_ferr;
  logic                    m_valid;
  logic [$clog2(DEPTH):0]  fifo_cnt;
  logic                    overrun;
  logic                    brk;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  int brk_cnt  = 0;
  int lat;
  int base;
  vec_t vecs[8];

  uart_rx_param_if #(.W(DW + 2)) mon ();
  assign mon.tdata  = {m_perr, m_ferr, m_data};
  assign mon.tvalid = m_valid;
  assign mon.tready = m_ready;

  uart_rx_param #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .OSR(16), .DIV_W(16)
  ) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .baud_div(baud_div),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .flush_i(flush),
    .rxd_i(rxd), .m_data_o(m_data), .m_perr_o(m_perr), .m_ferr_o(m_ferr),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .fifo_cnt_o(fifo_cnt),
    .overrun_o(overrun), .break_o(brk)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (brk)     brk_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic par_en, input logic par_val,
                      input logic st1, input logic st2);
    logic [11:0] f;
    int n;
    f      = '0;
    f[8:1] = d;
    n      = 9;
    if (par_en) begin f[n] = par_val; n++; end
    f[n] = st1; n++;
    if (stop_bits) begin f[n] = st2; n++; end
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      rxd = f[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic idle(input int bits);
    repeat (bits * BIT) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{PAR_EVEN, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{PAR_EVEN, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{PAR_ODD,  1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{PAR_ODD,  1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{PAR_NONE, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{PAR_NONE, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{PAR_NONE, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{2'b11,    1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk); #1;
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_cnt", fifo_cnt, 0);
    check_eq("rst_word", mon.tdata, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_break", brk, 0);
    rst = 1'b0;
    idle(1);

    // Basic frame and push latency
    lat = 0;
    fork
      send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clk);
        while (lat < 700) begin
          @(posedge clk);
          lat++;
          #1;
          if (m_valid) break;
        end
      end
    join
    check_eq("a5_latency_ok", (lat >= 600 && lat <= 640), 1);
    idle(1);
    check_eq("a5_data", m_data, 8'hA5);
    check_eq("a5_perr", m_perr, 0);
    check_eq("a5_ferr", m_ferr, 0);
    check_eq("a5_cnt", fifo_cnt, 1);
    pop();
    check_eq("a5_pop_valid", m_valid, 0);

    // Parity and stop-bit vectors
    for (int i = 0; i < 8; i++) begin
      parity_mode = vecs[i].mode;
      stop_bits   = vecs[i].two;
      send(vecs[i].d, (vecs[i].mode == PAR_ODD || vecs[i].mode == PAR_EVEN),
           vecs[i].par, vecs[i].st1, vecs[i].st2);
      idle(1);
      check_eq($sformatf("vec%0d_cnt", i), fifo_cnt, 1);
      check_eq($sformatf("vec%0d_word", i), mon.tdata, {vecs[i].perr, vecs[i].ferr, vecs[i].d});
      pop();
    end
    check_eq("vec_no_break", brk_cnt, 0);
    parity_mode = PAR_NONE;
    stop_bits   = 1'b0;

    // Break: line low for 12 bit times
    @(posedge clk); #1 rxd = 1'b0;
    repeat (12 * BIT) @(posedge clk);
    #1 rxd = 1'b1;
    idle(2);
    check_eq("brk_pulses", brk_cnt, 1);
    check_eq("brk_cnt", fifo_cnt, 1);
    check_eq("brk_word", mon.tdata, {1'b0, 1'b1, 8'h00});
    pop();

    // Short glitch is rejected, next frame still received
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    idle(2);
    check_eq("glitch_cnt", fifo_cnt, 0);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check_eq("post_glitch_word", mon.tdata, {2'b00, 8'h5A});

    // rx_en dropped mid-frame: no push, FIFO retained
    fork
      send(8'h96, 1'b0, 1'b0, 1'b1, 1'b1);
      begin @(posedge clk); repeat (300) @(posedge clk); #1 rx_en = 1'b0; end
    join
    idle(1);
    rx_en = 1'b1;
    idle(1);
    check_eq("abort_cnt", fifo_cnt, 1);
    check_eq("abort_head", m_data, 8'h5A);
    pop();

    // Overrun with consumer stalled
    base = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i * 8'h11), 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end
    check_eq("ovr_cnt_full", fifo_cnt, 4);
    check_eq("ovr_pulses", ovr_cnt - base, 1);
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("ovr_order%0d", i), m_data, 8'(i * 8'h11));
      pop();
    end
    check_eq("ovr_drained", fifo_cnt, 0);

    // Push into full FIFO with a simultaneous pop
    base = ovr_cnt;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i * 8'h11), 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end
    fork
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (619) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    idle(1);
    check_eq("pushpop_cnt", fifo_cnt, 4);
    check_eq("pushpop_no_ovr", ovr_cnt - base, 0);
    check_eq("pushpop_head", m_data, 8'h22);

    // Reset mid-data: partial frame discarded, no false start after release
    fork
      send(8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (288) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(6);
    check_eq("rstmid_cnt", fifo_cnt, 0);
    check_eq("rstmid_valid", m_valid, 0);

    // Flush covering a push into a full FIFO
    for (int i = 1; i <= 4; i++) begin
      send(8'(i * 8'h11), 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end
    check_eq("flush_prefill", fifo_cnt, 4);
    base = ovr_cnt;
    fork
      send(8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (612) @(posedge clk);
        #1 flush = 1'b1;
        repeat (16) @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    idle(1);
    check_eq("flush_cnt", fifo_cnt, 0);
    check_eq("flush_valid", m_valid, 0);
    check_eq("flush_no_ovr", ovr_cnt - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, 2..256.
REQ-003 SHALL have parameter OSR, default 16, oversampling ticks per bit, even, 8..32.
REQ-004 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-005 SHALL have these ports, clock and reset first:
 clk  in  1  single clock.
 rst  in  1  reset, asynchronous, active-high.
 rx_en  in  1  receiver enable.
 baud_div  in  DIV_W  one oversample tick every baud_div+1 clk cycles.
 parity_mode  in  2  00 none, 01 odd, 10 even, 11 treated as none.
 stop_bits  in  1  0: one stop bit, 1: two stop bits.
 flush_i  in  1  synchronous FIFO clear.
 rxd_i  in  1  asynchronous serial line, idle high.
 m_data_o  out  DATA_W  head-of-FIFO data.
 m_perr_o  out  1  parity error flag of the head word.
 m_ferr_o  out  1  framing error flag of the head word.
 m_valid_o  out  1  FIFO non-empty.
 m_ready_i  in  1  consumer accept; pop when m_valid_o and m_ready_i are both high.
 fifo_cnt_o  out  clog2(FIFO_DEPTH)+1  current occupancy.
 overrun_o  out  1  one-cycle pulse: a received word was dropped.
 break_o  out  1  one-cycle pulse: break frame detected.

Function
REQ-006 SHALL synchronise rxd_i through two flops; both flops SHALL reset to 1.
REQ-007 SHALL latch baud_div, parity_mode and stop_bits at start-edge detection and hold them for the whole frame.
REQ-008 SHALL run the FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-009 IDLE->START SHALL occur on a synchronised 1->0 edge while rx_en=1; the tick counter SHALL restart at that edge.
REQ-010 Every bit value SHALL be the 2-of-3 majority of the ticks at OSR/2-1, OSR/2 and OSR/2+1 within the bit.
REQ-011 In START, a majority of 1 SHALL return the FSM to IDLE, treating the edge as a glitch, with no push; otherwise the FSM SHALL enter DATA after OSR ticks.
REQ-012 DATA SHALL shift DATA_W bits LSB first, then go to PARITY if parity is enabled, else to STOP1.
REQ-013 Parity error SHALL be set when the received parity mismatches odd or even parity over the DATA_W data bits.
REQ-014 Framing error SHALL be set if any checked stop bit samples 0; STOP2 SHALL be checked only when stop_bits=1.
REQ-015 The push SHALL occur at the mid-bit sample of the last stop bit, after which the FSM returns to IDLE; the next start edge SHALL be accepted from the following cycle.
REQ-016 break_o SHALL pulse, and the word SHALL still be pushed with m_ferr_o=1, when all data bits, the parity bit if present and STOP1 sample 0.
REQ-017 The FIFO SHALL be show-ahead: m_data_o, m_perr_o and m_ferr_o are valid whenever m_valid_o=1, and m_valid_o rises the cycle after a push into an empty FIFO.
REQ-018 A push while full without a pop in the same cycle SHALL be dropped and SHALL pulse overrun_o; a push while full with a simultaneous pop SHALL be accepted.
REQ-019 A simultaneous push and pop at any occupancy SHALL leave fifo_cnt_o unchanged.
REQ-020 flush_i SHALL empty the FIFO the next cycle and override any pop or push in the same cycle; a word discarded this way SHALL NOT raise overrun_o.
REQ-021 Deasserting rx_en mid-frame SHALL abort the FSM to IDLE with no push; FIFO contents SHALL be retained.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_cnt_o SHALL reach FIFO_DEPTH exactly when full.

Reset
REQ-023 On rst: FSM=IDLE, tick, bit and FIFO pointers=0, m_valid_o=0, fifo_cnt_o=0, overrun_o=0, break_o=0, m_data_o=0, m_perr_o=0, m_ferr_o=0.
REQ-024 A reset mid-frame SHALL discard the partial frame; reception SHALL resume only on a new falling edge after release.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state enum, the parity_mode encodings and the default parameter constants.
REQ-026 The FIFO SHALL be a sub-module uart_sync_fifo, parametrised in width (DATA_W+2) and depth.

Verification
REQ-027 DATA_W=8, OSR=16, baud_div=3, no parity, 1 stop; send 0xA5 -> one push, m_data_o=0xA5, perr=0, ferr=0, m_valid_o high about 9.5*64 clk after the start edge.
REQ-028 Even parity; send 0x07 with parity bit 0 -> m_perr_o=1; resend with parity bit 1 -> m_perr_o=0.
REQ-029 DATA_W=8, no parity, 1 stop; hold rxd_i low for 12 bit times -> break_o pulses once; word 0x00 is pushed with ferr=1.
REQ-030 FIFO_DEPTH=4, m_ready_i=0; send 5 frames -> fifo_cnt_o=4, one overrun_o pulse, head=first byte; repeat with m_ready_i pulsed at the 5th push -> no overrun.
REQ-031 Low glitch of 3 clk on rxd_i -> FSM returns to IDLE and no push occurs.
REQ-032 Assert rst mid-DATA, then flush_i during a push -> no partial word is pushed; after the flush fifo_cnt_o=0 and overrun_o=0.
